mem_access_ctrl: RTL and testbench

Load/store sequencer between the KGP-RISC datapath and a synchronous block-RAM data memory. It accepts one `lw`/`sw` request at a time from the execute stage and converts the byte address into a word address. It drives the RAM port and waits out the configurable RAM read latency. It holds the pipeline through `busy`, returns the loaded word, and signals completion with a one-cycle `done` pulse.

---
 rtl/mem_access_ctrl_if.sv | 55 +++++
 rtl/mem_access_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Request-side bus between the KGP-RISC execute stage and the load/store
// sequencer (mem_access_ctrl).
//
// Signals:
//   req      requester -> ctrl : access request, level
//   we       requester -> ctrl : 1 = store (sw), 0 = load (lw)
//   addr     requester -> ctrl : byte address from the ALU
//   wdata    requester -> ctrl : store data
//   rdata    ctrl -> requester : last loaded word
//   busy     ctrl -> requester : pipeline stall (combinational)
//   done     ctrl -> requester : one-cycle completion pulse
//   misalign ctrl -> requester : rejected request, valid with done
//
// Modports:
//   master : the requester (datapath side)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              misalign;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  busy,
    input  done,
    input  misalign
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output busy,
    output done,
    output misalign
  );

endinterface : mem_access_ctrl_if

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Load/store sequencer between the KGP-RISC datapath and a synchronous
// block-RAM data memory. Accepts one lw/sw at a time, converts the byte
// address to a word address, drives the RAM port for a single cycle, waits
// out the RAM read latency for loads and reports completion with a
// one-cycle done pulse. Misaligned requests are rejected without touching
// the RAM.
//
// Parameters:
//   DATA_W  data word width
//   ADDR_W  RAM word-address width (depth 2^ADDR_W words)
//   RD_LAT  RAM read latency in cycles, 1..4
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   bus         request interface (slave side)
//   o_mem_en    RAM enable, registered
//   o_mem_we    RAM write enable, registered
//   o_mem_addr  RAM word address, registered
//   o_mem_din   RAM write data, registered
//   i_mem_dout  RAM read data, valid RD_LAT cycles after the enable edge
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_ctrl_if.slave     bus,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_din,
  input  logic [DATA_W-1:0]    i_mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  // Registered state
  state_t              r_state;
  logic                r_we;
  logic [2:0]          r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_done;
  logic                r_misalign;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;

  // Combinational next values
  state_t              w_next;
  logic                w_accept;
  logic                w_addr_misal;
  logic                w_we_nxt;
  logic [2:0]          w_cnt_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_done_nxt;
  logic                w_misalign_nxt;
  logic                w_mem_en_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_din_nxt;
  logic                w_busy;

  // Requests are only sampled when the sequencer can take a new one.
  assign w_accept     = ((r_state == S_IDLE) || (r_state == S_RESP)) && bus.req;
  assign w_addr_misal = (bus.addr[1:0] != 2'b00);

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (bus.req) begin
          // Misaligned requests skip the RAM and respond immediately.
          if (w_addr_misal) begin
            w_next = S_RESP;
          end else begin
            w_next = S_ISSUE;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Next values for the datapath and RAM-port registers.
  always_comb begin
    w_we_nxt       = r_we;
    w_cnt_nxt      = r_cnt;
    w_rdata_nxt    = r_rdata;
    w_mem_en_nxt   = 1'b0;
    w_mem_we_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_din_nxt  = r_mem_din;
    w_misalign_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_we_nxt = bus.we;
          if (w_addr_misal) begin
            w_misalign_nxt = 1'b1;
          end else begin
            // Upper address bits are dropped: the word address wraps.
            w_mem_addr_nxt = bus.addr[ADDR_W+1:2];
            w_mem_din_nxt  = bus.wdata;
            w_mem_we_nxt   = bus.we;
            w_mem_en_nxt   = 1'b1;
          end
        end else begin
          w_we_nxt = r_we;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_cnt_nxt = r_cnt;
        end else begin
          w_cnt_nxt = LAT_INIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        // Counter at 1 means the RAM output is valid on this edge.
        if (r_cnt == 3'd1) begin
          w_rdata_nxt = i_mem_dout;
        end else begin
          w_rdata_nxt = r_rdata;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
    w_done_nxt = (w_next == S_RESP);
  end

  // Stall: busy while an access is in flight or a request is being taken.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_ISSUE, S_WAIT: w_busy = 1'b1;
      S_IDLE, S_RESP:  w_busy = bus.req;
      default:         w_busy = 1'b0;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_cnt      <= 3'd0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_state    <= w_next;
      r_we       <= w_we_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rdata    <= w_rdata_nxt;
      r_done     <= w_done_nxt;
      r_misalign <= w_misalign_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_din  <= w_mem_din_nxt;
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.misalign = r_misalign;

  assign o_mem_en   = r_mem_en;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_mem_din;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Two sequencer instances (RD_LAT = 1 and RD_LAT = 3), each with its own
// block-RAM model. A reference model keeps the expected memory image, the
// expected last-loaded word and the expected latency of each request type.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int LAT0  = 1;
  localparam int LAT1  = 3;
  localparam int DEPTH = 1024;

  localparam int SEL_BUSY  = 0;
  localparam int SEL_DONE  = 1;
  localparam int SEL_MIS   = 2;
  localparam int SEL_RDATA = 3;
  localparam int SEL_EN    = 4;
  localparam int SEL_WE    = 5;
  localparam int SEL_ADDR  = 6;
  localparam int SEL_DIN   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus0 ();
  mem_access_ctrl_if bus1 ();

  logic        en0, we0, en1, we1;
  logic [9:0]  ad0, ad1;
  logic [31:0] din0, din1, dout0, dout1;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_LAT(LAT0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .o_mem_en(en0), .o_mem_we(we0), .o_mem_addr(ad0), .o_mem_din(din0),
    .i_mem_dout(dout0)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(10), .RD_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .o_mem_en(en1), .o_mem_we(we1), .o_mem_addr(ad1), .o_mem_din(din1),
    .i_mem_dout(dout1)
  );

  // RAM models; contents are not affected by the controller reset
  logic [31:0] ram0 [DEPTH];
  logic [31:0] ram1 [DEPTH];
  logic [31:0] p1a, p1b;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram0[i] <= 32'h5A00_0000 | 32'(i);
    end else if (en0) begin
      if (we0) ram0[ad0] <= din0;
      else     dout0 <= ram0[ad0];
    end
  end

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram1[i] <= 32'h5A00_0000 | 32'(i);
    end else if (en1 && !we1) begin
      p1a <= ram1[ad1];
    end else if (en1 && we1) begin
      ram1[ad1] <= din1;
    end
    p1b   <= p1a;
    dout1 <= p1b;
  end

  // Reference model state
  logic [31:0] mem_ref [2][DEPTH];
  logic [31:0] exp_rd  [2];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] obs(input int k, input int sel);
    logic [31:0] v;
    v = 32'd0;
    case (sel)
      SEL_BUSY:  v = 32'((k == 0) ? bus0.busy     : bus1.busy);
      SEL_DONE:  v = 32'((k == 0) ? bus0.done     : bus1.done);
      SEL_MIS:   v = 32'((k == 0) ? bus0.misalign : bus1.misalign);
      SEL_RDATA: v = (k == 0) ? bus0.rdata : bus1.rdata;
      SEL_EN:    v = 32'((k == 0) ? en0 : en1);
      SEL_WE:    v = 32'((k == 0) ? we0 : we1);
      SEL_ADDR:  v = 32'((k == 0) ? ad0 : ad1);
      SEL_DIN:   v = (k == 0) ? din0 : din1;
      default:   v = 32'hFFFF_FFFF;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (k == 0) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  task automatic drop_req(input int k);
    if (k == 0) bus0.req = 1'b0;
    else        bus1.req = 1'b0;
  endtask

  // One request, called just after a falling edge. Latency is counted in
  // cycles after the accepting edge; keep=1 leaves req high so the next
  // request is taken on the response edge.
  task automatic run_op(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit keep);
    int lat_exp, en_cnt, done_n, word;
    bit mis, busy_ok;
    logic [31:0] en_addr, en_we, en_din;
    mis     = (a[1:0] != 2'b00);
    word    = int'((a / 32'd4) % 32'(DEPTH));
    lat_exp = mis ? 1 : (w ? 2 : 2 + lat_of(k));
    en_cnt  = 0; done_n = 0; busy_ok = 1'b1;
    en_addr = 32'd0; en_we = 32'd0; en_din = 32'd0;
    drive(k, 1'b1, w, a, d);
    #1;
    chk("busy_on_req", obs(k, SEL_BUSY), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 12 && done_n == 0; n++) begin
      @(negedge clk);
      if (obs(k, SEL_EN) === 32'd1) begin
        en_cnt++;
        en_addr = obs(k, SEL_ADDR);
        en_we   = obs(k, SEL_WE);
        en_din  = obs(k, SEL_DIN);
      end
      if (obs(k, SEL_DONE) === 32'd1) done_n = n;
      else if (obs(k, SEL_BUSY) !== 32'd1) busy_ok = 1'b0;
    end
    if (!mis && w)  mem_ref[k][word] = d;
    if (!mis && !w) exp_rd[k] = mem_ref[k][word];
    chk("latency",  32'(done_n), 32'(lat_exp));
    chk("misalign", obs(k, SEL_MIS), 32'(mis));
    chk("rdata",    obs(k, SEL_RDATA), exp_rd[k]);
    chk("busy_hold", 32'(busy_ok), 32'd1);
    chk("mem_en_cycles", 32'(en_cnt), mis ? 32'd0 : 32'd1);
    if (!mis) begin
      chk("mem_addr", en_addr, 32'(word));
      chk("mem_we",   en_we,   32'(w));
      if (w) chk("mem_din", en_din, d);
    end
    if (!keep) begin
      drop_req(k);
      #1;
      chk("busy_idle", obs(k, SEL_BUSY), 32'd0);
    end
  endtask

  initial begin
    int k, pk, word, done_seen;
    logic w;
    logic [31:0] a, d;
    bit keep, pkeep;

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_ref[0][i] = 32'h5A00_0000 | 32'(i);
      mem_ref[1][i] = 32'h5A00_0000 | 32'(i);
    end
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("rst_rdata",    obs(j, SEL_RDATA), 32'd0);
      chk("rst_done",     obs(j, SEL_DONE),  32'd0);
      chk("rst_misalign", obs(j, SEL_MIS),   32'd0);
      chk("rst_mem_en",   obs(j, SEL_EN),    32'd0);
      chk("rst_mem_we",   obs(j, SEL_WE),    32'd0);
      chk("rst_mem_addr", obs(j, SEL_ADDR),  32'd0);
      chk("rst_mem_din",  obs(j, SEL_DIN),   32'd0);
      chk("rst_busy0",    obs(j, SEL_BUSY),  32'd0);
      drive(j, 1'b1, 1'b0, 32'd0, 32'd0);
      #1;
      chk("rst_busy_req", obs(j, SEL_BUSY),  32'd1);
      drop_req(j);
    end
    rst = 1'b0;
    ram_clr = 1'b0;
    @(negedge clk);

    // Store, load, misaligned on both latencies
    for (int j = 0; j < 2; j++) begin
      run_op(j, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      run_op(j, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
      chk("load_value", obs(j, SEL_RDATA), 32'hDEAD_BEEF);
      run_op(j, 1'b0, 32'h0000_0013, 32'd0, 1'b0);
      // Back-to-back store then load
      run_op(j, 1'b1, 32'h0000_0020, 32'h1234_5678 + 32'(j), 1'b1);
      run_op(j, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
    end

    // Address wrap: 0x1004 lands on word 1
    run_op(0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 1'b0);
    run_op(0, 1'b0, 32'h0000_0004, 32'd0, 1'b0);
    chk("wrap_load", obs(0, SEL_RDATA), 32'hCAFE_F00D);

    // Reset during the ISSUE cycle of a store
    run_op(0, 1'b1, 32'h0000_0040, 32'h0BAD_0001, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_0002);
    @(posedge clk);
    @(negedge clk);
    chk("issue_mem_en", obs(0, SEL_EN), 32'd1);
    rst = 1'b1;
    drop_req(0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    #1;
    chk("abort_mem_en", obs(0, SEL_EN),    32'd0);
    chk("abort_done",   obs(0, SEL_DONE),  32'd0);
    chk("abort_rdata",  obs(0, SEL_RDATA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (obs(0, SEL_DONE) === 32'd1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_op(0, 1'b0, 32'h0000_0040, 32'd0, 1'b0);
    chk("abort_old_value", obs(0, SEL_RDATA), 32'h0BAD_0001);

    // Randomized traffic against the reference model
    pkeep = 1'b0;
    pk = 0;
    for (int i = 0; i < 60; i++) begin
      k    = pkeep ? pk : int'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      word = int'($urandom_range(8, 15));
      a    = ($urandom & 32'hFFFF_F000) | 32'(word << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d    = $urandom;
      keep = (i != 59) && ($urandom_range(0, 2) == 0);
      run_op(k, w, a, d, keep);
      if (!keep && $urandom_range(0, 1) == 1) @(negedge clk);
      pkeep = keep;
      pk = k;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_access_ctrl
